// File: rtl/vedacao_ctrl_param.sv
// vedacao_ctrl_param: multi-cycle cork-press sealing controller with magazine tracking and a latched, coded alarm
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   garrafa      in   bottle present at station
//   pos          in   bottle positioned under press
//   rolha        in   cork feed sensor (1 = cork available)
//   refill       in   magazine reloaded, sampled every cycle
//   ack          in   operator alarm acknowledge (level)
//   ve           out  seal actuator enable
//   done         out  one-cycle pulse per completed seal
//   alarme       out  alarm active
//   alarm_code   out  00 none, 01 cork sensor, 10 magazine empty, 11 seal aborted
//   cork_cnt     out  corks remaining
//   low          out  cork_cnt <= LOW_THR
//   sealed_total out  completed seals, wraps
module vedacao_ctrl_param #(
    parameter int SEAL_CYCLES = 4,
    parameter int MAG_DEPTH   = 20,
    parameter int CNT_W       = 5,
    parameter int LOW_THR     = 2,
    parameter int TOT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             garrafa,
    input  logic             pos,
    input  logic             rolha,
    input  logic             refill,
    input  logic             ack,
    output logic             ve,
    output logic             done,
    output logic             alarme,
    output logic [1:0]       alarm_code,
    output logic [CNT_W-1:0] cork_cnt,
    output logic             low,
    output logic [TOT_W-1:0] sealed_total
);
    localparam int TW = (SEAL_CYCLES > 1) ? $clog2(SEAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAG_DEPTH);

    typedef enum logic [1:0] {IDLE, SEAL, RELEASE, ALARM} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            code_q  <= 2'b00;
            cnt_q   <= FULL;
            total_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        code_d  = code_q;
        cnt_d   = refill ? FULL : cnt_q;
        total_d = total_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rolha) begin
                    state_d = ALARM;
                    code_d  = 2'b01;
                end else if (cnt_q == '0) begin
                    state_d = ALARM;
                    code_d  = 2'b10;
                end else if (garrafa && pos) begin
                    state_d = SEAL;
                    timer_d = TW'(SEAL_CYCLES - 1);
                end
            end
            SEAL: begin
                // Losing the cork or the bottle aborts even on the last press cycle
                if (!rolha || !pos) begin
                    state_d = ALARM;
                    code_d  = 2'b11;
                end else if (timer_q == '0) begin
                    state_d = RELEASE;
                    done_d  = 1'b1;
                    cnt_d   = refill ? FULL : cnt_q - 1'b1;
                    total_d = total_q + 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            RELEASE: state_d = (!garrafa || !pos) ? IDLE : RELEASE;
            ALARM: begin
                if (ack && rolha && cnt_q != '0) begin
                    state_d = IDLE;
                    code_d  = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ve           = (state_q == SEAL);
    assign alarme       = (state_q == ALARM);
    assign done         = done_q;
    assign alarm_code   = code_q;
    assign cork_cnt     = cnt_q;
    assign low          = (cnt_q <= CNT_W'(LOW_THR));
    assign sealed_total = total_q;
endmodule

// File: tb/tb_vedacao_ctrl_param.sv
// tb_vedacao_ctrl_param: directed self-checking bench for the sealing-station controller
module tb_vedacao_ctrl_param;
    logic        clk = 1'b0;
    logic        reset, garrafa, pos, rolha, refill, ack;
    logic        ve, done, alarme, low;
    logic [1:0]  alarm_code;
    logic [4:0]  cork_cnt;
    logic [15:0] sealed_total;
    int          n_cmp = 0;
    int          n_bad = 0;

    vedacao_ctrl_param dut (
        .clk(clk), .reset(reset), .garrafa(garrafa), .pos(pos), .rolha(rolha),
        .refill(refill), .ack(ack), .ve(ve), .done(done), .alarme(alarme),
        .alarm_code(alarm_code), .cork_cnt(cork_cnt), .low(low),
        .sealed_total(sealed_total)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full seal from IDLE, then bottle removed so the FSM is back in IDLE
    task automatic do_seal();
        garrafa = 1'b1;
        pos     = 1'b1;
        repeat (5) tick();
        garrafa = 1'b0;
        pos     = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; garrafa = 1'b0; pos = 1'b0; rolha = 1'b1; refill = 1'b0; ack = 1'b0;
        tick();
        tick();
        n_cmp++; if (ve !== 1'b0) begin n_bad++; $display("FAIL reset_ve got %0b want 0", ve); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (alarme !== 1'b0 || alarm_code !== 2'b00) begin n_bad++; $display("FAIL reset_alarm got %0b/%0b want 0/00", alarme, alarm_code); end
        n_cmp++; if (cork_cnt !== 5'd20) begin n_bad++; $display("FAIL reset_cnt got %0d want 20", cork_cnt); end
        n_cmp++; if (sealed_total !== 16'd0 || low !== 1'b0) begin n_bad++; $display("FAIL reset_total_low got %0d/%0b want 0/0", sealed_total, low); end
        reset = 1'b0;
    endtask

    task automatic test_single_seal();
        logic [9:0] ve_h, done_h;
        garrafa = 1'b1;
        pos     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ve_h[i]   = ve;
            done_h[i] = done;
        end
        n_cmp++; if (ve_h !== 10'b0000001111) begin n_bad++; $display("FAIL seal_ve_hist got %b want 0000001111", ve_h); end
        n_cmp++; if (done_h !== 10'b0000010000) begin n_bad++; $display("FAIL seal_done_hist got %b want 0000010000", done_h); end
        n_cmp++; if (cork_cnt !== 5'd19) begin n_bad++; $display("FAIL seal_cnt got %0d want 19", cork_cnt); end
        n_cmp++; if (sealed_total !== 16'd1) begin n_bad++; $display("FAIL seal_total got %0d want 1", sealed_total); end
        garrafa = 1'b0;
        pos     = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        garrafa = 1'b1;
        pos     = 1'b1;
        tick();
        tick();
        n_cmp++; if (ve !== 1'b1) begin n_bad++; $display("FAIL abort_pre_ve got %0b want 1", ve); end
        pos = 1'b0;
        tick();
        n_cmp++; if (ve !== 1'b0 || alarme !== 1'b1) begin n_bad++; $display("FAIL abort_state got ve=%0b alarme=%0b want 0/1", ve, alarme); end
        n_cmp++; if (alarm_code !== 2'b11 || done !== 1'b0) begin n_bad++; $display("FAIL abort_code got %b done=%0b want 11/0", alarm_code, done); end
        n_cmp++; if (cork_cnt !== 5'd19 || sealed_total !== 16'd1) begin n_bad++; $display("FAIL abort_counts got %0d/%0d want 19/1", cork_cnt, sealed_total); end
        ack = 1'b1;
        tick();
        n_cmp++; if (alarme !== 1'b0 || alarm_code !== 2'b00) begin n_bad++; $display("FAIL abort_ack got %0b/%b want 0/00", alarme, alarm_code); end
        ack = 1'b0;
        pos = 1'b1;
        repeat (4) tick();
        n_cmp++; if (ve !== 1'b1) begin n_bad++; $display("FAIL reseal_ve got %0b want 1", ve); end
        tick();
        n_cmp++; if (done !== 1'b1 || ve !== 1'b0) begin n_bad++; $display("FAIL reseal_done got done=%0b ve=%0b want 1/0", done, ve); end
        n_cmp++; if (cork_cnt !== 5'd18 || sealed_total !== 16'd2) begin n_bad++; $display("FAIL reseal_counts got %0d/%0d want 18/2", cork_cnt, sealed_total); end
        garrafa = 1'b0;
        pos     = 1'b0;
        tick();
    endtask

    task automatic test_depletion();
        logic       low_seen;
        logic [4:0] low_at;
        low_seen = 1'b0;
        low_at   = '0;
        for (int i = 0; i < 18; i++) begin
            do_seal();
            if (low && !low_seen) begin
                low_seen = 1'b1;
                low_at   = cork_cnt;
            end
        end
        n_cmp++; if (low_at !== 5'd2) begin n_bad++; $display("FAIL low_first got %0d want 2", low_at); end
        n_cmp++; if (cork_cnt !== 5'd0 || sealed_total !== 16'd20) begin n_bad++; $display("FAIL deplete_counts got %0d/%0d want 0/20", cork_cnt, sealed_total); end
        garrafa = 1'b1;
        pos     = 1'b1;
        tick();
        n_cmp++; if (alarme !== 1'b1 || alarm_code !== 2'b10 || ve !== 1'b0) begin n_bad++; $display("FAIL empty_alarm got %0b/%b ve=%0b want 1/10/0", alarme, alarm_code, ve); end
        ack = 1'b1;
        tick();
        n_cmp++; if (alarme !== 1'b1 || ve !== 1'b0) begin n_bad++; $display("FAIL empty_ack_hold got %0b ve=%0b want 1/0", alarme, ve); end
        garrafa = 1'b0;
        pos     = 1'b0;
        refill  = 1'b1;
        tick();
        n_cmp++; if (cork_cnt !== 5'd20 || alarme !== 1'b1) begin n_bad++; $display("FAIL refill_in_alarm got %0d/%0b want 20/1", cork_cnt, alarme); end
        refill = 1'b0;
        tick();
        n_cmp++; if (alarme !== 1'b0 || alarm_code !== 2'b00 || cork_cnt !== 5'd20) begin n_bad++; $display("FAIL empty_exit got %0b/%b/%0d want 0/00/20", alarme, alarm_code, cork_cnt); end
        ack = 1'b0;
    endtask

    task automatic test_cork_fault();
        rolha = 1'b0;
        tick();
        n_cmp++; if (alarme !== 1'b1 || alarm_code !== 2'b01) begin n_bad++; $display("FAIL cork_alarm got %0b/%b want 1/01", alarme, alarm_code); end
        ack = 1'b1;
        tick();
        n_cmp++; if (alarme !== 1'b1) begin n_bad++; $display("FAIL cork_ack_hold got %0b want 1", alarme); end
        rolha = 1'b1;
        tick();
        n_cmp++; if (alarme !== 1'b0 || alarm_code !== 2'b00) begin n_bad++; $display("FAIL cork_exit got %0b/%b want 0/00", alarme, alarm_code); end
        ack = 1'b0;
    endtask

    task automatic test_refill_coincident();
        for (int i = 0; i < 15; i++) do_seal();
        n_cmp++; if (cork_cnt !== 5'd5 || sealed_total !== 16'd35) begin n_bad++; $display("FAIL pre_coinc got %0d/%0d want 5/35", cork_cnt, sealed_total); end
        garrafa = 1'b1;
        pos     = 1'b1;
        repeat (4) tick();
        refill = 1'b1;
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL coinc_done got %0b want 1", done); end
        n_cmp++; if (cork_cnt !== 5'd20 || sealed_total !== 16'd36) begin n_bad++; $display("FAIL coinc_counts got %0d/%0d want 20/36", cork_cnt, sealed_total); end
        refill  = 1'b0;
        garrafa = 1'b0;
        pos     = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_seal();
        n_cmp++; if (cork_cnt !== 5'd19 || sealed_total !== 16'd37) begin n_bad++; $display("FAIL pre_reset got %0d/%0d want 19/37", cork_cnt, sealed_total); end
        garrafa = 1'b1;
        pos     = 1'b1;
        tick();
        tick();
        n_cmp++; if (ve !== 1'b1) begin n_bad++; $display("FAIL midseal_ve got %0b want 1", ve); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (ve !== 1'b0 || done !== 1'b0 || alarme !== 1'b0) begin n_bad++; $display("FAIL async_outs got ve=%0b done=%0b alarme=%0b want 0/0/0", ve, done, alarme); end
        n_cmp++; if (cork_cnt !== 5'd20 || sealed_total !== 16'd0) begin n_bad++; $display("FAIL async_counts got %0d/%0d want 20/0", cork_cnt, sealed_total); end
        garrafa = 1'b0;
        pos     = 1'b0;
        #3 reset = 1'b0;
        tick();
        n_cmp++; if (ve !== 1'b0 || alarme !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got ve=%0b alarme=%0b want 0/0", ve, alarme); end
        garrafa = 1'b1;
        pos     = 1'b1;
        tick();
        n_cmp++; if (ve !== 1'b1) begin n_bad++; $display("FAIL post_reset_seal got %0b want 1", ve); end
    endtask

    initial begin
        test_reset();
        test_single_seal();
        test_abort();
        test_depletion();
        test_cork_fault();
        test_refill_coincident();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vedacao_ctrl_param.md
Name: vedacao_ctrl_param

Overview:
Parametrised sealing-station controller. Drives the cork-press actuator for a programmable number of cycles per bottle and tracks a cork magazine count with a refill input. Raises a latched, coded alarm that needs an operator acknowledge to clear. Sits after the filling stage on the conveyor and takes the same bottle-present, position and cork-sensor inputs as the existing single-cycle sealing FSM.

Parameters:
SEAL_CYCLES, 4, cycles ve is held high per bottle (>=1)
MAG_DEPTH, 20, corks in a full magazine; value loaded on reset and on refill
CNT_W, 5, width of cork_cnt (must hold MAG_DEPTH)
LOW_THR, 2, low asserted when cork_cnt <= LOW_THR
TOT_W, 16, width of sealed_total counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clock clk
garrafa  in  1  bottle present at station
pos  in  1  bottle correctly positioned under press
rolha  in  1  cork feed sensor (1 = cork available at press)
refill  in  1  magazine reloaded; sampled each cycle
ack  in  1  operator alarm acknowledge (level)
ve  out  1  seal actuator enable
done  out  1  one-cycle pulse per completed seal
alarme  out  1  alarm active
alarm_code  out  2  00 none, 01 cork sensor fault, 10 magazine empty, 11 seal aborted
cork_cnt  out  CNT_W  corks remaining
low  out  1  cork_cnt <= LOW_THR (combinational from cork_cnt)
sealed_total  out  TOT_W  completed seals, wraps modulo 2^TOT_W

Behaviour:
- Reset (async, immediate): state IDLE, timer 0, ve=0, done=0, alarme=0, alarm_code=00, cork_cnt=MAG_DEPTH, sealed_total=0. Asserting reset mid-seal drops ve at once; nothing is counted.
- States: IDLE, SEAL, RELEASE, ALARM. ve = (state==SEAL). alarme = (state==ALARM). alarm_code is registered, nonzero only in ALARM.
- IDLE transitions, in priority order:
  - rolha==0 -> ALARM, code 01.
  - else cork_cnt==0 -> ALARM, code 10.
  - else garrafa&&pos -> SEAL, timer loaded with SEAL_CYCLES-1.
  - else stay in IDLE.
- SEAL transitions, checked each cycle:
  - rolha==0 or pos==0 -> ALARM, code 11. Abort: no done, no count change. This has priority even on the final cycle.
  - else timer==0 -> RELEASE.
  - else timer decrements.
- SEAL timing: ve is high exactly SEAL_CYCLES consecutive cycles.
- SEAL -> RELEASE edge: done=1 for exactly that one following cycle (first RELEASE cycle). On the same edge, cork_cnt decrements and sealed_total increments.
- RELEASE: ve=0. Stay until garrafa==0 or pos==0, then go to IDLE. A bottle left in place is never sealed twice.
- ALARM: ve=0. Exit to IDLE only when ack==1 && rolha==1 && cork_cnt!=0, all sampled in the same cycle. alarm_code returns to 00 on exit. A bottle still in place is sealed starting the cycle after IDLE is re-entered.
- refill==1: cork_cnt <= MAG_DEPTH next edge, in any state. When refill coincides with the seal-complete decrement, refill wins (result MAG_DEPTH). A refill does not itself clear ALARM; ack is still required and sees the updated count from the next cycle.
- cork_cnt never decrements below 0; this is guaranteed because SEAL is entered only with cork_cnt!=0.
- sealed_total wraps from 2^TOT_W-1 to 0 with no flag.

Test Plan:
1. Reset, rolha=1, garrafa=pos=1 held for 10 cycles -> ve high for exactly 4 cycles; done pulses once in the cycle after ve falls; cork_cnt 20->19; sealed_total 0->1; no second seal while bottle stays.
2. Mid-seal abort: drop pos in the 2nd SEAL cycle -> ve falls next edge; alarme=1, code 11; cork_cnt unchanged; ack=1 with rolha=1 -> IDLE; the same bottle, repositioned, then seals normally.
3. Magazine depletion: 20 bottles sealed -> cork_cnt 0; low first seen when cork_cnt=2; next bottle -> ALARM code 10 with ve never asserted; ack alone holds ALARM; refill, then ack -> IDLE, cork_cnt=20.
4. Cork sensor fault: rolha=0 in IDLE -> ALARM code 01; ack=1 while rolha=0 keeps ALARM; rolha=1 with ack -> IDLE.
5. Refill coincident with seal completion at cork_cnt=5 -> cork_cnt=20 (not 19); done still pulses; sealed_total increments.
6. Async reset asserted mid-SEAL between clock edges -> ve=0 immediately; cork_cnt=20; sealed_total=0; after release, state is IDLE.
